answer_checker: RTL and testbench
=================================

# answer_checker

Consumer of the game's 32-bit random answer word. Captures `rand` on each `write_enable` pulse from the random generator and scores player guesses against it. A guess is eight 4-bit digits, each 1..8. Each accepted guess is scored iteratively as strikes (right digit, right position) and balls (right digit, wrong position, multiset semantics), with a one-cycle result pulse back to the game controller.

## Interface
- No parameters; digit count (8) and digit range (1..8) are fixed.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `write_enable` in 1: one-cycle pulse; load `rand` as the new answer.
- `rand` in 32: answer word, nibble 7 (bits 31:28) = digit 0 … nibble 0 = digit 7.
- `guess_valid` in 1: guess offered.
- `guess` in 32: guess word, same nibble layout as `rand`.
- `guess_ready` out 1: block will accept a guess this cycle.
- `answer_loaded` out 1: at least one answer captured since reset.
- `result_valid` out 1: one-cycle pulse, result fields valid.
- `strikes` out 4: 0..8, held until next result.
- `balls` out 4: 0..8, held until next result.
- `solved` out 1: strikes == 8, held with result.
- `invalid` out 1: the scored guess had a digit outside 1..8, held with result.
- `attempts` out 4: guesses accepted since last answer load, saturates at 15.

## Operation
- States: IDLE (no answer), READY, SCAN, TALLY, DONE.
- Answer capture:
  - `write_enable`=1 on any edge, in any state, writes `rand` into the answer register, sets `answer_loaded`, and clears `attempts` to 0.
  - In IDLE it also moves the FSM to READY.
- Accepting a guess:
  - `guess_ready` = 1 only in READY. Acceptance is `guess_valid && guess_ready` on an edge.
  - On acceptance: copy the guess and the *current* answer register (pre-edge value) into work registers, clear counters and both 8-entry 4-bit histograms, set idx=0, and go to SCAN.
  - `attempts` increments (saturating at 15) unless `write_enable` is high on the same edge; then the clear wins.
- SCAN (8 cycles, idx 0..7), per digit:
  - If the guess digit equals the answer digit and the digit is in 1..8: strike+1.
  - Increment the answer histogram for answer digits in 1..8.
  - Increment the guess histogram for guess digits in 1..8.
  - Set the invalid flag if the guess digit is 0 or 9..15. Answer digits outside 1..8 never match.
  - idx==7 → TALLY, idx reset to 0.
- TALLY (8 cycles, symbol s = 1..8): common += min(ans_hist[s], gss_hist[s]). Last symbol → DONE.
- DONE (1 cycle):
  - `result_valid`=1.
  - If invalid: `strikes`=`balls`=0, `solved`=0, `invalid`=1.
  - Otherwise: `strikes`=strike count, `balls`=common − strikes (never negative by construction), `solved`=(strikes==8), `invalid`=0.
  - Then → READY.
- A new `write_enable` during SCAN/TALLY/DONE never affects the in-flight result; it only changes the answer used for later guesses.
- Widths: histograms 4 bits (max 8), common 4 bits (max 8), strikes 4 bits.

## Timing
- Reset values: state IDLE, answer 0, all outputs 0 (`guess_ready`=0, `answer_loaded`=0, `result_valid`=0, `strikes`=`balls`=0, `solved`=`invalid`=0, `attempts`=0).
- Reset mid-SCAN/TALLY: immediate return to IDLE. The in-flight result is discarded and no `result_valid` is produced.
- `answer_loaded` and `guess_ready` rise in the cycle after the first `write_enable` edge.
- Latency: acceptance on edge E0 → `result_valid` high for exactly the cycle between edge E16 and edge E17. Result fields update at edge E16.
- `guess_ready` is low from E0 until E17, so throughput is one guess per 17 cycles.
- `guess_valid` while `guess_ready`=0 is ignored. The source must hold the guess until accepted.
- Result fields hold their values until the next DONE or reset.

## Test plan
- Reset, then `guess_valid`=1 with no `write_enable` → `guess_ready` stays 0 and nothing is accepted. Pulse `write_enable` with `rand`=0x12345678 → `answer_loaded`=1 and `guess_ready`=1 next cycle.
- Answer 0x12345678:
  - Guess 0x12345678 → 16 cycles later `result_valid` pulse, strikes=8, balls=0, solved=1, attempts=1.
  - Then guess 0x87654321 → strikes=0, balls=8, solved=0, attempts=2.
- Answer 0x11223344, guess 0x12121212 → strikes=2, balls=2. Guess 0x44332211 → strikes=0, balls=8.
- Answer 0x12345678, guess 0x12345670 → invalid=1, strikes=0, balls=0, solved=0.
- Accept guess 0x12345678 against answer 0x12345678. At E5, `write_enable` loads 0x87654321 → the in-flight result is still strikes=8 and attempts reads 0. The next guess 0x87654321 scores strikes=8.
- Assert `rst` at E8 during SCAN → no `result_valid`, all outputs 0, state IDLE. `guess_ready`=0 until the next `write_enable`.

Source files
------------

// File: rtl/answer_checker.sv
// answer_checker
// Holds the game's 32-bit answer word and scores player guesses against it.
// A guess is eight 4-bit digits (nibble 7 = digit 0 ... nibble 0 = digit 7),
// each legal digit being 1..8. Scoring runs iteratively: eight SCAN cycles
// count strikes and build per-symbol histograms, eight TALLY cycles sum the
// per-symbol minima (multiset common count), and a one-cycle DONE state
// presents the result. Acceptance edge E0 -> result_valid between E16 and E17.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   write_enable   one-cycle pulse: load rand_word as the new answer
//   rand_word      answer word ("rand" is a reserved word in SystemVerilog)
//   guess_valid    guess offered on guess
//   guess          guess word, same nibble layout as rand_word
//   guess_ready    block accepts a guess this cycle (READY only)
//   answer_loaded  at least one answer captured since reset
//   result_valid   one-cycle pulse, result fields valid
//   strikes        right digit, right position (0..8), held until next result
//   balls          right digit, wrong position (0..8), held until next result
//   solved         strikes == 8, held with result
//   invalid        scored guess contained a digit outside 1..8
//   attempts       guesses accepted since last answer load, saturates at 15
module answer_checker (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_enable,
    input  logic [31:0] rand_word,
    input  logic        guess_valid,
    input  logic [31:0] guess,
    output logic        guess_ready,
    output logic        answer_loaded,
    output logic        result_valid,
    output logic [3:0]  strikes,
    output logic [3:0]  balls,
    output logic        solved,
    output logic        invalid,
    output logic [3:0]  attempts
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_SCAN  = 3'd2,
        ST_TALLY = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d >= 4'd1) && (d <= 4'd8);
    endfunction

    function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t      state_r;
    logic [31:0] answer_r;
    logic [31:0] work_guess_r;
    logic [31:0] work_ans_r;
    logic [2:0]  idx_r;
    logic [3:0]  strike_cnt_r;
    logic [3:0]  common_r;
    logic        bad_r;
    logic [3:0]  ans_hist_r [0:7];
    logic [3:0]  gss_hist_r [0:7];

    logic [3:0]  g_dig_s;
    logic [3:0]  a_dig_s;
    logic [2:0]  g_hidx_s;
    logic [2:0]  a_hidx_s;
    logic [3:0]  common_sum_s;
    logic        accept_s;

    // Digit selection for SCAN and running common sum for TALLY.
    always_comb begin
        // Digit idx lives at nibble (7 - idx); ~idx equals 7 - idx for 3 bits.
        g_dig_s      = work_guess_r[{~idx_r, 2'b00} +: 4];
        a_dig_s      = work_ans_r[{~idx_r, 2'b00} +: 4];
        // Symbol s (1..8) maps to histogram slot s-1; 8 wraps to slot 7.
        g_hidx_s     = g_dig_s[2:0] - 3'd1;
        a_hidx_s     = a_dig_s[2:0] - 3'd1;
        common_sum_s = common_r + min4(ans_hist_r[idx_r], gss_hist_r[idx_r]);
        accept_s     = guess_valid && guess_ready;
    end

    // Answer register, load flag and attempt counter (load clears attempts).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            answer_r      <= 32'd0;
            answer_loaded <= 1'b0;
            attempts      <= 4'd0;
        end else if (write_enable) begin
            answer_r      <= rand_word;
            answer_loaded <= 1'b1;
            attempts      <= 4'd0;
        end else if (accept_s && (attempts != 4'd15)) begin
            attempts <= attempts + 4'd1;
        end
    end

    // Scoring FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            guess_ready  <= 1'b0;
            result_valid <= 1'b0;
            strikes      <= 4'd0;
            balls        <= 4'd0;
            solved       <= 1'b0;
            invalid      <= 1'b0;
            work_guess_r <= 32'd0;
            work_ans_r   <= 32'd0;
            idx_r        <= 3'd0;
            strike_cnt_r <= 4'd0;
            common_r     <= 4'd0;
            bad_r        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ans_hist_r[i] <= 4'd0;
                gss_hist_r[i] <= 4'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (write_enable) begin
                        state_r     <= ST_READY;
                        guess_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (guess_valid) begin
                        // Snapshot the pre-edge answer so a same-edge load
                        // only affects later guesses.
                        work_guess_r <= guess;
                        work_ans_r   <= answer_r;
                        idx_r        <= 3'd0;
                        strike_cnt_r <= 4'd0;
                        common_r     <= 4'd0;
                        bad_r        <= 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            ans_hist_r[i] <= 4'd0;
                            gss_hist_r[i] <= 4'd0;
                        end
                        guess_ready <= 1'b0;
                        state_r     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if ((g_dig_s == a_dig_s) && digit_ok(g_dig_s)) begin
                        strike_cnt_r <= strike_cnt_r + 4'd1;
                    end
                    if (digit_ok(a_dig_s)) begin
                        ans_hist_r[a_hidx_s] <= ans_hist_r[a_hidx_s] + 4'd1;
                    end
                    if (digit_ok(g_dig_s)) begin
                        gss_hist_r[g_hidx_s] <= gss_hist_r[g_hidx_s] + 4'd1;
                    end else begin
                        bad_r <= 1'b1;
                    end
                    if (idx_r == 3'd7) begin
                        idx_r   <= 3'd0;
                        state_r <= ST_TALLY;
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                ST_TALLY: begin
                    common_r <= common_sum_s;
                    if (idx_r == 3'd7) begin
                        // Final symbol: publish using the completed sum.
                        idx_r        <= 3'd0;
                        state_r      <= ST_DONE;
                        result_valid <= 1'b1;
                        invalid      <= bad_r;
                        if (bad_r) begin
                            strikes <= 4'd0;
                            balls   <= 4'd0;
                            solved  <= 1'b0;
                        end else begin
                            strikes <= strike_cnt_r;
                            // Strikes are a subset of common, so no underflow.
                            balls   <= common_sum_s - strike_cnt_r;
                            solved  <= (strike_cnt_r == 4'd8);
                        end
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                ST_DONE: begin
                    result_valid <= 1'b0;
                    guess_ready  <= 1'b1;
                    state_r      <= ST_READY;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    guess_ready  <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_answer_checker.sv
// Directed testbench for answer_checker: each scenario task drives stimulus
// and compares outputs against hand-computed expectations.
module tb_answer_checker;

    logic        clk;
    logic        rst;
    logic        write_enable;
    logic [31:0] rand_word;
    logic        guess_valid;
    logic [31:0] guess;
    logic        guess_ready;
    logic        answer_loaded;
    logic        result_valid;
    logic [3:0]  strikes;
    logic [3:0]  balls;
    logic        solved;
    logic        invalid;
    logic [3:0]  attempts;

    int checks = 0;
    int errors = 0;

    answer_checker dut (
        .clk           (clk),
        .rst           (rst),
        .write_enable  (write_enable),
        .rand_word     (rand_word),
        .guess_valid   (guess_valid),
        .guess         (guess),
        .guess_ready   (guess_ready),
        .answer_loaded (answer_loaded),
        .result_valid  (result_valid),
        .strikes       (strikes),
        .balls         (balls),
        .solved        (solved),
        .invalid       (invalid),
        .attempts      (attempts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load a new answer with a single write_enable edge.
    task automatic load_answer(input logic [31:0] v);
        @(negedge clk);
        write_enable = 1'b1;
        rand_word    = v;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    // Offer a guess once ready; return cycles from acceptance to result_valid
    // (-1 if no result within the budget). Returns 1ns after the result edge.
    task automatic do_guess(input logic [31:0] g, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!guess_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        guess       = g;
        guess_valid = 1'b1;
        @(posedge clk);
        #1;
        guess_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (guess_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", guess_ready); end
        checks++; if (answer_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded: got %b expected 0", answer_loaded); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", result_valid); end
        checks++; if ({strikes, balls, solved, invalid, attempts} !== 14'd0) begin errors++; $display("FAIL rst_fields: got %h expected 0", {strikes, balls, solved, invalid, attempts}); end
        rst = 1'b0;
        guess       = 32'h12345678;
        guess_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (guess_ready !== 1'b0) begin errors++; $display("FAIL noans_ready: got %b expected 0", guess_ready); end
        checks++; if (attempts !== 4'd0) begin errors++; $display("FAIL noans_attempts: got %0d expected 0", attempts); end
        guess_valid = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL noans_valid: got %b expected 0", result_valid); end
    endtask

    task automatic test_first_load;
        load_answer(32'h12345678);
        checks++; if (answer_loaded !== 1'b1) begin errors++; $display("FAIL load_loaded: got %b expected 1", answer_loaded); end
        checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", guess_ready); end
    endtask

    task automatic test_exact_and_reverse;
        int lat;
        do_guess(32'h12345678, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL exact_latency: got %0d expected 16", lat); end
        checks++; if (strikes !== 4'd8) begin errors++; $display("FAIL exact_strikes: got %0d expected 8", strikes); end
        checks++; if (balls !== 4'd0) begin errors++; $display("FAIL exact_balls: got %0d expected 0", balls); end
        checks++; if (solved !== 1'b1) begin errors++; $display("FAIL exact_solved: got %b expected 1", solved); end
        checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL exact_invalid: got %b expected 0", invalid); end
        checks++; if (attempts !== 4'd1) begin errors++; $display("FAIL exact_attempts: got %0d expected 1", attempts); end
        checks++; if (guess_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %b expected 0", guess_ready); end
        @(posedge clk);
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b expected 0", result_valid); end
        checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL ready_again: got %b expected 1", guess_ready); end
        checks++; if (strikes !== 4'd8) begin errors++; $display("FAIL hold_strikes: got %0d expected 8", strikes); end
        do_guess(32'h87654321, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL rev_latency: got %0d expected 16", lat); end
        checks++; if (strikes !== 4'd0) begin errors++; $display("FAIL rev_strikes: got %0d expected 0", strikes); end
        checks++; if (balls !== 4'd8) begin errors++; $display("FAIL rev_balls: got %0d expected 8", balls); end
        checks++; if (solved !== 1'b0) begin errors++; $display("FAIL rev_solved: got %b expected 0", solved); end
        checks++; if (attempts !== 4'd2) begin errors++; $display("FAIL rev_attempts: got %0d expected 2", attempts); end
    endtask

    task automatic test_multiset;
        int lat;
        load_answer(32'h11223344);
        checks++; if (attempts !== 4'd0) begin errors++; $display("FAIL ms_attempts_clr: got %0d expected 0", attempts); end
        do_guess(32'h12121212, lat);
        checks++; if (strikes !== 4'd2) begin errors++; $display("FAIL ms1_strikes: got %0d expected 2", strikes); end
        checks++; if (balls !== 4'd2) begin errors++; $display("FAIL ms1_balls: got %0d expected 2", balls); end
        checks++; if (attempts !== 4'd1) begin errors++; $display("FAIL ms1_attempts: got %0d expected 1", attempts); end
        do_guess(32'h44332211, lat);
        checks++; if (strikes !== 4'd0) begin errors++; $display("FAIL ms2_strikes: got %0d expected 0", strikes); end
        checks++; if (balls !== 4'd8) begin errors++; $display("FAIL ms2_balls: got %0d expected 8", balls); end
    endtask

    task automatic test_invalid;
        int lat;
        load_answer(32'h12345678);
        do_guess(32'h12345670, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL inv_latency: got %0d expected 16", lat); end
        checks++; if (invalid !== 1'b1) begin errors++; $display("FAIL inv_flag: got %b expected 1", invalid); end
        checks++; if (strikes !== 4'd0) begin errors++; $display("FAIL inv_strikes: got %0d expected 0", strikes); end
        checks++; if (balls !== 4'd0) begin errors++; $display("FAIL inv_balls: got %0d expected 0", balls); end
        checks++; if (solved !== 1'b0) begin errors++; $display("FAIL inv_solved: got %b expected 0", solved); end
    endtask

    task automatic test_load_during_scan;
        int lat;
        int n;
        n = 0;
        @(negedge clk);
        while (!guess_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        guess       = 32'h12345678;
        guess_valid = 1'b1;
        @(posedge clk);              // E0
        #1;
        guess_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                write_enable = 1'b1;
                rand_word    = 32'h87654321;
            end
            @(posedge clk);
            #1;
            write_enable = 1'b0;
            if (result_valid) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 16) begin errors++; $display("FAIL wscan_latency: got %0d expected 16", lat); end
        checks++; if (strikes !== 4'd8) begin errors++; $display("FAIL wscan_strikes: got %0d expected 8", strikes); end
        checks++; if (solved !== 1'b1) begin errors++; $display("FAIL wscan_solved: got %b expected 1", solved); end
        checks++; if (attempts !== 4'd0) begin errors++; $display("FAIL wscan_attempts: got %0d expected 0", attempts); end
        do_guess(32'h87654321, lat);
        checks++; if (strikes !== 4'd8) begin errors++; $display("FAIL newans_strikes: got %0d expected 8", strikes); end
        checks++; if (attempts !== 4'd1) begin errors++; $display("FAIL newans_attempts: got %0d expected 1", attempts); end
    endtask

    task automatic test_reset_mid_scan;
        int n;
        logic seen;
        n = 0;
        @(negedge clk);
        while (!guess_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        guess       = 32'h87654321;
        guess_valid = 1'b1;
        @(posedge clk);              // E0
        #1;
        guess_valid = 1'b0;
        repeat (7) @(posedge clk);   // E7
        #1;
        rst = 1'b1;
        @(posedge clk);              // E8
        #1;
        checks++; if ({guess_ready, answer_loaded, result_valid} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags: got %b expected 000", {guess_ready, answer_loaded, result_valid}); end
        checks++; if ({strikes, balls, solved, invalid, attempts} !== 14'd0) begin errors++; $display("FAIL mid_rst_fields: got %h expected 0", {strikes, balls, solved, invalid, attempts}); end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (result_valid || guess_ready) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_quiet: got %b expected 0", seen); end
        load_answer(32'h12345678);
        checks++; if (guess_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_reload: got %b expected 1", guess_ready); end
    endtask

    initial begin
        rst          = 1'b1;
        write_enable = 1'b0;
        rand_word    = 32'd0;
        guess_valid  = 1'b0;
        guess        = 32'd0;
        test_reset();
        test_first_load();
        test_exact_and_reverse();
        test_multiset();
        test_invalid();
        test_load_during_scan();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
